// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide issue scheduler: op codes, request and
// result records, and the scheduler state encoding.
package mdu_pkg;

   localparam int MDU_TAG_W = 6;

   typedef enum logic [2:0] {
      OP_MUL   = 3'd0,
      OP_MULH  = 3'd1,
      OP_MULHU = 3'd2,
      OP_RSVD  = 3'd3,
      OP_DIV   = 3'd4,
      OP_DIVU  = 3'd5,
      OP_MOD   = 3'd6,
      OP_MODU  = 3'd7
   } mdu_op_e;

   typedef struct packed {
      mdu_op_e               op;
      logic [1:0][31:0]      data;
      logic [MDU_TAG_W-1:0]  rob_id;
   } mdu_req_t;

   typedef struct packed {
      logic [31:0]           data;
      logic [MDU_TAG_W-1:0]  rob_id;
   } mdu_res_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV_RUN,
      S_DIV_HOLD
   } sched_state_e;

   // Bit 2 of the op code selects the divider; everything else is a multiply.
   function automatic logic is_div_op(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/mdu_res_buf.sv
// Small synchronous FIFO holding multiplier results until the output drains them.
// DEPTH may be any value >= 1; pointers wrap by explicit compare.
module mdu_res_buf #(
   parameter int DEPTH = 3,
   parameter int W = 32,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  pop_data,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign empty    = (count == '0);

   assert property (@(posedge clk) disable iff (!rst_n || clear) push |-> (count < CW'(DEPTH)) || pop);
   assert property (@(posedge clk) disable iff (!rst_n || clear) pop |-> !empty);

endmodule

// File: rtl/mdu_sched.sv
// Issue-side scheduler for the MDU: routes requests to the pipelined multiplier or
// the iterative divider and returns results in acceptance order.
module mdu_sched
   import mdu_pkg::*;
#(
   parameter int MUL_LAT    = 2,
   parameter int TAG_W      = MDU_TAG_W,
   parameter int RBUF_DEPTH = MUL_LAT + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [2:0]            req_op_i,
   input  logic [1:0][31:0]      req_data_i,
   input  logic [TAG_W-1:0]      req_rob_id_i,
   output logic                  mul_valid_o,
   output logic [1:0]            mul_op_o,
   output logic [31:0]           mul_a_o,
   output logic [31:0]           mul_b_o,
   input  logic [31:0]           mul_res_i,
   output logic                  div_start_o,
   output logic [1:0]            div_op_o,
   output logic [31:0]           div_a_o,
   output logic [31:0]           div_b_o,
   output logic                  div_abort_o,
   input  logic                  div_done_i,
   input  logic [31:0]           div_res_i,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [31:0]           res_data_o,
   output logic [TAG_W-1:0]      res_rob_id_o
);

   localparam int CW = $clog2(RBUF_DEPTH + 1);

   if (TAG_W != MDU_TAG_W) begin : g_tag_w_check
      $error("mdu_sched: TAG_W must match mdu_pkg::MDU_TAG_W");
   end

   // Handshakes: a transfer happens on a cycle where valid & ready are both 1 at the
   // clock edge; valid never depends on ready, and payload is held while valid & !ready.
   sched_state_e        state, state_nxt;
   logic [CW-1:0]       credit_cnt, credit_nxt;
   mdu_req_t            req_q;
   logic [2:0]          op_bits;
   logic                mul_valid_q, div_start_q;
   logic [MUL_LAT-1:0]  tag_v;
   logic [MUL_LAT-1:0][TAG_W-1:0] tag_p;
   mdu_res_t            hold_q, buf_head, push_word, res_word;
   logic                buf_empty;
   logic [CW-1:0]       buf_count;
   logic                req_is_div, accept, mul_acc, div_acc, push, pop;
   mdu_op_e             op_in;

   assign req_is_div = is_div_op(req_op_i);
   assign op_in      = (req_op_i == OP_RSVD) ? OP_MUL : mdu_op_e'(req_op_i);

   always_comb begin
      req_ready_o = 1'b0;
      if (!flush) begin
         if (req_is_div) req_ready_o = (state == S_IDLE);
         else            req_ready_o = ((state == S_IDLE) || (state == S_MUL)) &&
                                       (credit_cnt < CW'(RBUF_DEPTH));
      end
   end

   assign accept  = req_valid_i && req_ready_o;
   assign mul_acc = accept && !req_is_div;
   assign div_acc = accept && req_is_div;
   assign push    = tag_v[MUL_LAT-1];
   assign pop     = !buf_empty && res_ready_i;

   always_comb begin
      credit_nxt = credit_cnt;
      if (mul_acc && !pop)      credit_nxt = credit_cnt + CW'(1);
      else if (!mul_acc && pop) credit_nxt = credit_cnt - CW'(1);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (mul_acc) state_nxt = S_MUL;
                     else if (div_acc) state_nxt = S_DIV_RUN;
         S_MUL:      if (credit_nxt == '0) state_nxt = S_IDLE;
         S_DIV_RUN:  if (div_done_i) state_nxt = S_DIV_HOLD;
         S_DIV_HOLD: if (res_ready_i) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // The tag pipe is aligned so its last stage is valid in the cycle mul_res_i is.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         state       <= S_IDLE;
         credit_cnt  <= '0;
         req_q       <= '0;
         mul_valid_q <= 1'b0;
         div_start_q <= 1'b0;
         tag_v       <= '0;
         tag_p       <= '0;
         hold_q      <= '0;
      end else begin
         state       <= state_nxt;
         credit_cnt  <= credit_nxt;
         mul_valid_q <= mul_acc;
         div_start_q <= div_acc;
         if (accept) begin
            req_q.op     <= op_in;
            req_q.data   <= req_data_i;
            req_q.rob_id <= req_rob_id_i;
         end
         tag_v[0] <= mul_valid_q;
         tag_p[0] <= req_q.rob_id;
         for (int i = 1; i < MUL_LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_p[i] <= tag_p[i-1];
         end
         if (state == S_DIV_RUN && div_done_i) begin
            hold_q.data   <= div_res_i;
            hold_q.rob_id <= req_q.rob_id;
         end
      end
   end

   always_comb begin
      push_word        = '0;
      push_word.data   = mul_res_i;
      push_word.rob_id = tag_p[MUL_LAT-1];
   end

   mdu_res_buf #(
      .DEPTH (RBUF_DEPTH),
      .W     ($bits(mdu_res_t))
   ) u_res_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (flush),
      .push      (push),
      .push_data (push_word),
      .pop       (pop),
      .pop_data  (buf_head),
      .empty     (buf_empty),
      .count     (buf_count)
   );

   // Divide issue needs zero credits, so the buffer and the hold register never compete.
   always_comb begin
      res_word = '0;
      if (!buf_empty)                res_word = buf_head;
      else if (state == S_DIV_HOLD)  res_word = hold_q;
   end

   assign op_bits      = req_q.op;
   assign mul_valid_o  = mul_valid_q;
   assign mul_op_o     = op_bits[1:0];
   assign mul_a_o      = req_q.data[0];
   assign mul_b_o      = req_q.data[1];
   assign div_start_o  = div_start_q;
   assign div_op_o     = op_bits[1:0];
   assign div_a_o      = req_q.data[0];
   assign div_b_o      = req_q.data[1];
   assign div_abort_o  = flush && (state == S_DIV_RUN);
   assign res_valid_o  = !buf_empty || (state == S_DIV_HOLD);
   assign res_data_o   = res_word.data;
   assign res_rob_id_o = res_word.rob_id;

   assert property (@(posedge clk) disable iff (!rst_n) buf_count <= credit_cnt);
   assert property (@(posedge clk) disable iff (!rst_n) mul_valid_o |-> !op_bits[2]);

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: expected results are queued at issue and a
// negedge monitor compares every output handshake against the queue.
module tb_mdu_sched;
  localparam int MUL_LAT = 2;
  localparam int TAG_W = 6;
  localparam int RW = 32 + TAG_W;

  logic clk = 1'b0;
  logic rst_n, flush, req_valid_i, req_ready_o;
  logic [2:0] req_op_i;
  logic [1:0][31:0] req_data_i;
  logic [TAG_W-1:0] req_rob_id_i;
  logic mul_valid_o;
  logic [1:0] mul_op_o;
  logic [31:0] mul_a_o, mul_b_o, mul_res_i;
  logic div_start_o, div_abort_o, div_done_i;
  logic [1:0] div_op_o;
  logic [31:0] div_a_o, div_b_o, div_res_i;
  logic res_valid_o, res_ready_i;
  logic [31:0] res_data_o;
  logic [TAG_W-1:0] res_rob_id_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_exp;
  logic [31:0] mp [0:MUL_LAT];

  mdu_sched #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_data_i(req_data_i), .req_rob_id_i(req_rob_id_i),
    .mul_valid_o(mul_valid_o), .mul_op_o(mul_op_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_res_i(mul_res_i),
    .div_start_o(div_start_o), .div_op_o(div_op_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_abort_o(div_abort_o), .div_done_i(div_done_i), .div_res_i(div_res_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_rob_id_o(res_rob_id_o)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // multiplier engine model: result of the operands seen with mul_valid_o
  // appears on mul_res_i exactly MUL_LAT cycles later
  initial for (int i = 0; i <= MUL_LAT; i++) mp[i] = 32'hBAD0_BAD0;
  always @(negedge clk) begin
    for (int i = MUL_LAT; i > 0; i--) mp[i] = mp[i-1];
    mp[0] = mul_valid_o ? mul_a_o * mul_b_o : 32'hBAD0_BAD0;
    mul_res_i = mp[MUL_LAT];
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && !flush && res_valid_o && res_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result actual=%0h/rob%0d required=none", res_data_o, res_rob_id_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({res_data_o, res_rob_id_o} !== mon_exp) begin
          failures++;
          $display("FAIL result actual=%0h/rob%0d required=%0h/rob%0d",
                   res_data_o, res_rob_id_o, mon_exp[RW-1:TAG_W], mon_exp[TAG_W-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] rob, output int acc);
    int n;
    n = 0;
    req_valid_i = 1'b1;
    req_op_i = op;
    req_data_i[0] = a;
    req_data_i[1] = b;
    req_rob_id_i = rob;
    #1;
    while (!req_ready_o && n < 200) begin
      next();
      #1;
      n++;
    end
    chk("issue_ready", {63'd0, req_ready_o}, 64'd1);
    acc = cyc;
    next();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_res(output int c);
    int n;
    n = 0;
    while (!res_valid_o && n < 50) begin
      next();
      n++;
    end
    chk("res_valid_seen", {63'd0, res_valid_o}, 64'd1);
    c = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      next();
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    next();
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [TAG_W-1:0] rob);
    exp_q.push_back({d, rob});
  endtask

  initial begin
    int t0, t1, t2, t3, tr;
    rst_n = 1'b0; flush = 1'b0; req_valid_i = 1'b0; req_op_i = 3'd0;
    req_data_i = '0; req_rob_id_i = '0; div_done_i = 1'b0; div_res_i = '0;
    res_ready_i = 1'b0;
    repeat (3) next();

    // reset state
    chk("rst_res_valid", {63'd0, res_valid_o}, 64'd0);
    chk("rst_mul_valid", {63'd0, mul_valid_o}, 64'd0);
    chk("rst_div_start", {63'd0, div_start_o}, 64'd0);
    chk("rst_div_abort", {63'd0, div_abort_o}, 64'd0);
    chk("rst_res_data", {32'd0, res_data_o}, 64'd0);
    chk("rst_mul_a", {32'd0, mul_a_o}, 64'd0);
    rst_n = 1'b1;
    next();
    chk("post_rst_ready", {63'd0, req_ready_o}, 64'd1);

    // single MUL 3*5 rob 7
    res_ready_i = 1'b1;
    push_exp(32'd15, 6'd7);
    issue(3'd0, 32'd3, 32'd5, 6'd7, t0);
    chk("mul1_valid_t1", {63'd0, mul_valid_o}, 64'd1);
    chk("mul1_a", {32'd0, mul_a_o}, 64'd3);
    chk("mul1_b", {32'd0, mul_b_o}, 64'd5);
    chk("mul1_op", {62'd0, mul_op_o}, 64'd0);
    next();
    chk("mul1_valid_pulse", {63'd0, mul_valid_o}, 64'd0);
    wait_res(tr);
    chk("mul1_res_latency", 64'(tr - t0), 64'd4);
    drain();

    // five MULs with output stalled: only three credits
    res_ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      push_exp(32'(i * (i + 10)), 6'(i));
      issue(3'd0, 32'(i), 32'(i + 10), 6'(i), t0);
    end
    req_valid_i = 1'b1; req_op_i = 3'd0; req_rob_id_i = 6'd4;
    req_data_i[0] = 32'd4; req_data_i[1] = 32'd14;
    #1;
    chk("full_ready_low", {63'd0, req_ready_o}, 64'd0);
    repeat (5) next();
    chk("full_ready_still_low", {63'd0, req_ready_o}, 64'd0);
    chk("full_head_valid", {63'd0, res_valid_o}, 64'd1);
    chk("full_head_data", {32'd0, res_data_o}, 64'd11);
    chk("full_head_rob", {58'd0, res_rob_id_o}, 64'd1);
    res_ready_i = 1'b1;
    push_exp(32'd56, 6'd4);
    issue(3'd0, 32'd4, 32'd14, 6'd4, t0);
    push_exp(32'd75, 6'd5);
    issue(3'd0, 32'd5, 32'd15, 6'd5, t0);
    drain();

    // MUL then DIV: divide waits for the multiply to drain
    push_exp(32'd42, 6'd1);
    issue(3'd0, 32'd6, 32'd7, 6'd1, t0);
    push_exp(32'd14, 6'd2);
    issue(3'd4, 32'd100, 32'd7, 6'd2, t1);
    chk("div_stall_cycles", 64'(t1 - t0), 64'd5);
    chk("div_start", {63'd0, div_start_o}, 64'd1);
    chk("div_a", {32'd0, div_a_o}, 64'd100);
    chk("div_b", {32'd0, div_b_o}, 64'd7);
    chk("div_op", {62'd0, div_op_o}, 64'd0);
    req_op_i = 3'd0;
    for (int i = 1; i <= 9; i++) begin
      next();
      chk("divrun_ready", {63'd0, req_ready_o}, 64'd0);
      chk("divrun_no_res", {63'd0, res_valid_o}, 64'd0);
    end
    chk("div_start_pulse", {63'd0, div_start_o}, 64'd0);
    next();
    div_done_i = 1'b1; div_res_i = 32'd14;
    t2 = cyc;
    next();
    div_done_i = 1'b0; div_res_i = 32'hFFFF_FFFF;
    chk("div_res_next_cycle", {63'd0, res_valid_o}, 64'd1);
    chk("div_res_cycle", 64'(cyc - t2), 64'd1);
    drain();

    // DIV held with output stalled
    res_ready_i = 1'b0;
    push_exp(32'd3, 6'd9);
    issue(3'd6, 32'd23, 32'd5, 6'd9, t0);
    chk("mod_op_bits", {62'd0, div_op_o}, 64'd2);
    next(); next();
    div_done_i = 1'b1; div_res_i = 32'd3;
    next();
    div_done_i = 1'b0; div_res_i = 32'hFFFF_FFFF;
    req_valid_i = 1'b1; req_op_i = 3'd0; req_rob_id_i = 6'd12;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", {63'd0, res_valid_o}, 64'd1);
      chk("hold_data", {32'd0, res_data_o}, 64'd3);
      chk("hold_rob", {58'd0, res_rob_id_o}, 64'd9);
      chk("hold_ready", {63'd0, req_ready_o}, 64'd0);
      next();
    end
    req_valid_i = 1'b0;
    res_ready_i = 1'b1;
    next();
    req_op_i = 3'd4;
    #1;
    chk("hold_to_idle_ready", {63'd0, req_ready_o}, 64'd1);
    chk("hold_to_idle_no_res", {63'd0, res_valid_o}, 64'd0);
    chk("hold_queue_empty", 64'(exp_q.size()), 64'd0);

    // flush during DIV_RUN with a MUL waiting behind it
    issue(3'd5, 32'd50, 32'd5, 6'd10, t0);
    req_valid_i = 1'b1; req_op_i = 3'd0; req_rob_id_i = 6'd11;
    next(); next();
    flush = 1'b1;
    #1;
    chk("flush_abort", {63'd0, div_abort_o}, 64'd1);
    chk("flush_ready_low", {63'd0, req_ready_o}, 64'd0);
    next();
    flush = 1'b0;
    req_valid_i = 1'b0;
    #1;
    chk("post_flush_ready", {63'd0, req_ready_o}, 64'd1);
    chk("post_flush_no_res", {63'd0, res_valid_o}, 64'd0);
    chk("post_flush_abort", {63'd0, div_abort_o}, 64'd0);
    div_done_i = 1'b1; div_res_i = 32'hDEAD_BEEF;
    next();
    div_done_i = 1'b0;
    req_op_i = 3'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("late_done_ignored", {63'd0, res_valid_o}, 64'd0);
      chk("late_done_idle", {63'd0, req_ready_o}, 64'd1);
      next();
    end

    // flush with two multiplies in flight
    issue(3'd0, 32'd9, 32'd9, 6'd20, t0);
    issue(3'd0, 32'd8, 32'd8, 6'd21, t1);
    flush = 1'b1;
    next();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("flushed_mul_hidden", {63'd0, res_valid_o}, 64'd0);
      next();
    end
    res_ready_i = 1'b0;
    push_exp(32'd6, 6'd30);
    issue(3'd1, 32'd2, 32'd3, 6'd30, t1);
    chk("mulh_op", {62'd0, mul_op_o}, 64'd1);
    push_exp(32'd20, 6'd31);
    issue(3'd2, 32'd4, 32'd5, 6'd31, t2);
    chk("mulhu_op", {62'd0, mul_op_o}, 64'd2);
    push_exp(32'd42, 6'd32);
    issue(3'd3, 32'd6, 32'd7, 6'd32, t3);
    chk("rsvd_as_mul_op", {62'd0, mul_op_o}, 64'd0);
    chk("refill_b2b_1", 64'(t2 - t1), 64'd1);
    chk("refill_b2b_2", 64'(t3 - t2), 64'd1);
    req_op_i = 3'd0;
    #1;
    chk("refill_full", {63'd0, req_ready_o}, 64'd0);
    res_ready_i = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
